// File: rtl/uart_cmd_slave_if.sv
`timescale 1ns/1ps
// uart_cmd_slave_if
// Register-port bundle between the UART command responder and the register file.
//   reg_wr    : one-cycle write strobe
//   reg_rd    : one-cycle read strobe
//   reg_addr  : register address, held from decode until the responder idles
//   reg_wdata : write data, valid with reg_wr
//   reg_rdata : read data, valid the cycle after reg_rd
// Modports: master = command responder side, slave = register file side.
interface uart_cmd_slave_if #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  reg_wr;
    logic                  reg_rd;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic [DATA_WIDTH-1:0] reg_rdata;

    modport master (
        output reg_wr,
        output reg_rd,
        output reg_addr,
        output reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  reg_wr,
        input  reg_rd,
        input  reg_addr,
        input  reg_wdata,
        output reg_rdata
    );
endinterface

// File: rtl/uart_cmd_slave.sv
`timescale 1ns/1ps
// uart_cmd_slave
// UART command responder. Receives a command byte (bit7 = write, bits6:0 = address),
// plus a data byte for writes, and drives a register port. Reads are answered with
// one UART frame carrying the register value. Half-duplex, one command in flight.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   rx          : UART serial input (asynchronous, idle high)
//   tx          : UART serial output (idle high)
//   reg_if      : register port (uart_cmd_slave_if.master)
//   busy        : high whenever the FSM is not idle
//   err_parity  : one-cycle pulse on a parity mismatch
//   err_frame   : one-cycle pulse when a stop bit is sampled low
// Build option: define UART_CMD_PARITY_EN to add an even-parity bit to every frame
// (checked on receive, generated on transmit). Without it frames are 10 bits long
// and err_parity is tied low.
module uart_cmd_slave #(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    output logic             tx,
    uart_cmd_slave_if.master reg_if,
    output logic             busy,
    output logic             err_parity,
    output logic             err_frame
);

    localparam int unsigned      CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(CLK_DIV / 2 - 1);

    // Bit index within a frame: 0 = start, 1..8 = data, [9 = parity], LAST_BIT = stop.
`ifdef UART_CMD_PARITY_EN
    localparam logic [3:0]  LAST_BIT = 4'd10;
    localparam int unsigned TX_W     = DATA_WIDTH + 2;
`else
    localparam logic [3:0]  LAST_BIT = 4'd9;
    localparam int unsigned TX_W     = DATA_WIDTH + 1;
`endif

    typedef enum logic [2:0] {
        IDLE,
        RX_CMD,
        RX_DATA,
        WRITE,
        READ,
        CAPTURE,
        TX_RESP,
        WAIT_IDLE
    } state_t;

    state_t state_q, state_d;

    logic                  rx_s1, rx_s2, rx_d;
    logic                  rx_fall;
    logic                  rx_busy;
    logic                  rx_sample;
    logic [CNT_W-1:0]      cnt;
    logic [3:0]            bit_idx;
    logic [DATA_WIDTH-1:0] sh;
    logic [TX_W-1:0]       tx_sh;
    logic                  tx_q;
    logic [ADDR_WIDTH-1:0] reg_addr_q;
    logic [DATA_WIDTH-1:0] reg_wdata_q;
    logic                  err_frame_q;
`ifdef UART_CMD_PARITY_EN
    logic                  par_acc;
    logic                  err_parity_q;
`endif

    // Two-stage synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign rx_fall   = rx_d & ~rx_s2;
    // rx_busy separates an active frame from RX_DATA's wait for the data byte.
    assign rx_sample = rx_busy && (state_q == RX_CMD || state_q == RX_DATA) && (cnt == CNT_MID);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_fall) state_d = RX_CMD;
            end
            RX_CMD, RX_DATA: begin
                if (rx_sample) begin
                    if (bit_idx == 4'd0) begin
                        if (rx_s2) state_d = IDLE;
                    end else if (bit_idx == LAST_BIT) begin
                        // Framing takes priority over parity.
                        if (!rx_s2) state_d = WAIT_IDLE;
`ifdef UART_CMD_PARITY_EN
                        else if (par_acc) state_d = IDLE;
`endif
                        else if (state_q == RX_DATA) state_d = WRITE;
                        else if (sh[DATA_WIDTH-1]) state_d = RX_DATA;
                        else state_d = READ;
                    end
                end
            end
            WRITE:   state_d = IDLE;
            READ:    state_d = CAPTURE;
            CAPTURE: state_d = TX_RESP;
            TX_RESP: begin
                if (cnt == CNT_MAX && bit_idx == LAST_BIT) state_d = IDLE;
            end
            WAIT_IDLE: begin
                if (rx_s2 && cnt == CNT_MAX) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        reg_if.reg_wr = (state_q == WRITE);
        reg_if.reg_rd = (state_q == READ);
        busy          = (state_q != IDLE);
    end

    assign reg_if.reg_addr  = reg_addr_q;
    assign reg_if.reg_wdata = reg_wdata_q;
    assign tx               = tx_q;
    assign err_frame        = err_frame_q;
`ifdef UART_CMD_PARITY_EN
    assign err_parity       = err_parity_q;
`else
    assign err_parity       = 1'b0;
`endif

    // Datapath: bit timing, receive shift, transmit shift, latched register port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy      <= 1'b0;
            cnt          <= '0;
            bit_idx      <= '0;
            sh           <= '0;
            tx_sh        <= '1;
            tx_q         <= 1'b1;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            err_frame_q  <= 1'b0;
`ifdef UART_CMD_PARITY_EN
            par_acc      <= 1'b0;
            err_parity_q <= 1'b0;
`endif
        end else begin
            err_frame_q  <= 1'b0;
`ifdef UART_CMD_PARITY_EN
            err_parity_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    tx_q    <= 1'b1;
                    rx_busy <= rx_fall;
                    cnt     <= '0;
                    bit_idx <= '0;
`ifdef UART_CMD_PARITY_EN
                    par_acc <= 1'b0;
`endif
                end
                RX_CMD, RX_DATA: begin
                    if (!rx_busy) begin
                        rx_busy <= rx_fall;
                        cnt     <= '0;
                        bit_idx <= '0;
`ifdef UART_CMD_PARITY_EN
                        par_acc <= 1'b0;
`endif
                    end else begin
                        cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
                        if (rx_sample) begin
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx >= 4'd1 && bit_idx <= 4'd8) begin
                                sh <= {rx_s2, sh[DATA_WIDTH-1:1]};
`ifdef UART_CMD_PARITY_EN
                                par_acc <= par_acc ^ rx_s2;
`endif
                            end
`ifdef UART_CMD_PARITY_EN
                            if (bit_idx == 4'd9) par_acc <= par_acc ^ rx_s2;
`endif
                            if (bit_idx == LAST_BIT) begin
                                rx_busy <= 1'b0;
                                cnt     <= '0;
                                if (!rx_s2) err_frame_q <= 1'b1;
`ifdef UART_CMD_PARITY_EN
                                else if (par_acc) err_parity_q <= 1'b1;
`endif
                                else if (state_q == RX_CMD) reg_addr_q <= sh[ADDR_WIDTH-1:0];
                                else reg_wdata_q <= sh;
                            end
                        end
                    end
                end
                CAPTURE: begin
`ifdef UART_CMD_PARITY_EN
                    tx_sh <= {1'b1, ^reg_if.reg_rdata, reg_if.reg_rdata};
`else
                    tx_sh <= {1'b1, reg_if.reg_rdata};
`endif
                    tx_q    <= 1'b0;
                    cnt     <= '0;
                    bit_idx <= '0;
                end
                TX_RESP: begin
                    if (cnt == CNT_MAX) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        tx_q    <= tx_sh[0];
                        tx_sh   <= {1'b1, tx_sh[TX_W-1:1]};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    tx_q <= 1'b1;
                    cnt  <= rx_s2 ? cnt + 1'b1 : '0;
                end
                default: begin
                    tx_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_slave.sv
`timescale 1ns/1ps
// tb_uart_cmd_slave
// Directed bench for uart_cmd_slave with CLK_DIV = 16. Follows UART_CMD_PARITY_EN
// (11-bit frames when defined, 10-bit frames otherwise).
module tb_uart_cmd_slave;

    localparam int unsigned CLK_DIV = 16;
`ifdef UART_CMD_PARITY_EN
    localparam int unsigned NBITS   = 11;
`else
    localparam int unsigned NBITS   = 10;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    logic tx;
    logic busy;
    logic err_parity;
    logic err_frame;

    int unsigned n_run  = 0;
    int unsigned n_fail = 0;

    // Event counters kept by the monitor below.
    int unsigned wr_cnt     = 0;
    int unsigned rd_cnt     = 0;
    int unsigned perr_cnt   = 0;
    int unsigned ferr_cnt   = 0;
    int unsigned tx_low_cnt = 0;
    logic [6:0]  last_waddr = '0;
    logic [7:0]  last_wdata = '0;
    logic [6:0]  last_raddr = '0;

    int unsigned b_wr, b_rd, b_pe, b_fe, b_txl;

    uart_cmd_slave_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) reg_if ();

    uart_cmd_slave #(
        .CLK_DIV   (CLK_DIV),
        .ADDR_WIDTH(7),
        .DATA_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .tx        (tx),
        .reg_if    (reg_if.master),
        .busy      (busy),
        .err_parity(err_parity),
        .err_frame (err_frame)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_if.reg_wr === 1'b1) begin
            wr_cnt++;
            last_waddr = reg_if.reg_addr;
            last_wdata = reg_if.reg_wdata;
        end
        if (reg_if.reg_rd === 1'b1) begin
            rd_cnt++;
            last_raddr = reg_if.reg_addr;
        end
        if (err_parity === 1'b1) perr_cnt++;
        if (err_frame === 1'b1)  ferr_cnt++;
        if (tx !== 1'b1)         tx_low_cnt++;
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives start + data (+ parity), then leaves rx at the stop level and returns.
`ifdef UART_CMD_PARITY_EN
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input logic par_flip = 1'b0);
`else
    task automatic send_frame(input logic [7:0] b, input logic stop_val);
`endif
        logic [7:0] bv;
        bv = b;
        rx = 1'b0;
        tick(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rx = bv[i];
            tick(CLK_DIV);
        end
`ifdef UART_CMD_PARITY_EN
        rx = (^bv) ^ par_flip;
        tick(CLK_DIV);
`endif
        rx = stop_val;
    endtask

    task automatic wait_tx_low(output logic found);
        int unsigned waited;
        waited = 0;
        while (tx !== 1'b0 && waited < 64) begin
            tick(1);
            waited++;
        end
        found = (tx === 1'b0);
    endtask

    // Waits for the response start bit, checks every bit mid-way and the busy drop.
    task automatic check_tx_frame(input logic [7:0] d, input string tag);
        logic [NBITS-1:0] exp_bits;
        logic             found;
`ifdef UART_CMD_PARITY_EN
        exp_bits = {1'b1, ^d, d, 1'b0};
`else
        exp_bits = {1'b1, d, 1'b0};
`endif
        wait_tx_low(found);
        check({tag, "_start_seen"}, {15'd0, found}, 16'd1);
        tick(CLK_DIV / 2);
        for (int k = 0; k < NBITS; k++) begin
            check($sformatf("%s_bit%0d", tag, k), {15'd0, tx}, {15'd0, exp_bits[k]});
            if (k < NBITS - 1) tick(CLK_DIV);
        end
        tick(CLK_DIV / 2 - 1);
        check({tag, "_busy_last_cycle"}, {15'd0, busy}, 16'd1);
        tick(1);
        check({tag, "_busy_after"}, {15'd0, busy}, 16'd0);
        check({tag, "_tx_idle"}, {15'd0, tx}, 16'd1);
    endtask

    initial begin
        logic found;

        rst_n = 1'b0;
        rx = 1'b1;
        reg_if.reg_rdata = 8'h00;
        tick(3);

        // Reset state
        check("rst_tx",         {15'd0, tx},               16'd1);
        check("rst_busy",       {15'd0, busy},             16'd0);
        check("rst_reg_wr",     {15'd0, reg_if.reg_wr},    16'd0);
        check("rst_reg_rd",     {15'd0, reg_if.reg_rd},    16'd0);
        check("rst_reg_addr",   {9'd0, reg_if.reg_addr},   16'd0);
        check("rst_reg_wdata",  {8'd0, reg_if.reg_wdata},  16'd0);
        check("rst_err_parity", {15'd0, err_parity},       16'd0);
        check("rst_err_frame",  {15'd0, err_frame},        16'd0);
        rst_n = 1'b1;
        tick(5);

        // Write 0x3C to address 0x05
        b_wr = wr_cnt; b_txl = tx_low_cnt;
        send_frame(8'h85, 1'b1);
        tick(CLK_DIV);
        check("wr_wait_data_busy", {15'd0, busy}, 16'd1);
        check("wr_no_early_strobe", 16'(wr_cnt - b_wr), 16'd0);
        send_frame(8'h3C, 1'b1);
        tick(CLK_DIV);
        check("wr_count",   16'(wr_cnt - b_wr),      16'd1);
        check("wr_addr",    {9'd0, last_waddr},      16'h0005);
        check("wr_data",    {8'd0, last_wdata},      16'h003C);
        check("wr_tx_idle", 16'(tx_low_cnt - b_txl), 16'd0);
        check("wr_busy_end", {15'd0, busy},          16'd0);

        // Read address 0x12, register returns 0xA5
        reg_if.reg_rdata = 8'hA5;
        b_rd = rd_cnt; b_wr = wr_cnt;
        send_frame(8'h12, 1'b1);
        check_tx_frame(8'hA5, "rd");
        tick(2);
        check("rd_count", 16'(rd_cnt - b_rd), 16'd1);
        check("rd_addr",  {9'd0, last_raddr}, 16'h0012);
        check("rd_no_wr", 16'(wr_cnt - b_wr), 16'd0);

`ifdef UART_CMD_PARITY_EN
        // Parity error on a write command, then a clean read of 0x01
        b_wr = wr_cnt; b_rd = rd_cnt; b_pe = perr_cnt; b_fe = ferr_cnt;
        send_frame(8'h85, 1'b1, 1'b1);
        tick(CLK_DIV + 4);
        check("pe_err_parity", 16'(perr_cnt - b_pe), 16'd1);
        check("pe_err_frame",  16'(ferr_cnt - b_fe), 16'd0);
        check("pe_no_wr",      16'(wr_cnt - b_wr),   16'd0);
        check("pe_no_rd",      16'(rd_cnt - b_rd),   16'd0);
        check("pe_idle",       {15'd0, busy},        16'd0);
        reg_if.reg_rdata = 8'h5A;
        send_frame(8'h01, 1'b1);
        check_tx_frame(8'h5A, "pe_rd");
        tick(2);
        check("pe_rd_count", 16'(rd_cnt - b_rd), 16'd1);
        check("pe_rd_addr",  {9'd0, last_raddr}, 16'h0001);
`endif

        // Framing error on a read command, rx held low for 40 cycles
        b_rd = rd_cnt; b_pe = perr_cnt; b_fe = ferr_cnt;
        send_frame(8'h01, 1'b0);
        tick(40);
        rx = 1'b1;
        check("fe_err_frame",  16'(ferr_cnt - b_fe), 16'd1);
        check("fe_err_parity", 16'(perr_cnt - b_pe), 16'd0);
        check("fe_no_rd",      16'(rd_cnt - b_rd),   16'd0);
        check("fe_busy_hold",  {15'd0, busy},        16'd1);
        tick(17);
        check("fe_busy_last",  {15'd0, busy},        16'd1);
        tick(1);
        check("fe_busy_drop",  {15'd0, busy},        16'd0);

        // 4-cycle glitch: false start, no error
        b_pe = perr_cnt; b_fe = ferr_cnt;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        check("gl_busy_start", {15'd0, busy}, 16'd1);
        tick(14);
        check("gl_busy_back",  {15'd0, busy}, 16'd0);
        tick(10);
        check("gl_no_err_frame",  16'(ferr_cnt - b_fe), 16'd0);
        check("gl_no_err_parity", 16'(perr_cnt - b_pe), 16'd0);

        // Reset in the middle of a read response
        reg_if.reg_rdata = 8'h00;
        send_frame(8'h33, 1'b1);
        wait_tx_low(found);
        check("rs_start_seen", {15'd0, found}, 16'd1);
        tick(CLK_DIV + 4);
        check("rs_tx_in_frame", {15'd0, tx}, 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_tx_async",   {15'd0, tx},            16'd1);
        check("rs_busy_async", {15'd0, busy},          16'd0);
        check("rs_rd_low",     {15'd0, reg_if.reg_rd}, 16'd0);
        b_wr = wr_cnt; b_rd = rd_cnt; b_txl = tx_low_cnt;
        tick(3);
        rst_n = 1'b1;
        tick(200);
        check("rs_no_tx_output", 16'(tx_low_cnt - b_txl), 16'd0);
        check("rs_no_wr",        16'(wr_cnt - b_wr),      16'd0);
        check("rs_no_rd",        16'(rd_cnt - b_rd),      16'd0);
        check("rs_idle",         {15'd0, busy},           16'd0);

        // Whole-run error pulse totals
`ifdef UART_CMD_PARITY_EN
        check("total_err_parity", 16'(perr_cnt), 16'd1);
`else
        check("total_err_parity", 16'(perr_cnt), 16'd0);
`endif
        check("total_err_frame", 16'(ferr_cnt), 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_slave.md
# uart_cmd_slave

UART command responder: the far end of the team's UART command master. Receives 8-bit command frames on `rx`, decodes write/read, and drives a simple register port. On a read it returns the register value as one UART frame on `tx`. Sits between the board UART pins and the on-chip register file; half-duplex, one command in flight.

## Interface
- `CLK_DIV`, 434: clock cycles per UART bit; must be ≥ 8 and even.
- `ADDR_WIDTH`, 7: register address width; fixed at 7 by the frame format.
- `DATA_WIDTH`, 8: register data width; fixed at 8.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  UART serial input, asynchronous to `clk`, idle high.
- `tx`  out  1  UART serial output, idle high; reset 1.
- `reg_wr`  out  1  one-cycle write strobe; reset 0.
- `reg_rd`  out  1  one-cycle read strobe; reset 0.
- `reg_addr`  out  7  register address, held from decode until return to IDLE; reset 0.
- `reg_wdata`  out  8  write data, valid with `reg_wr`; reset 0.
- `reg_rdata`  in  8  read data, valid the cycle after `reg_rd`.
- `busy`  out  1  high in any state other than IDLE; reset 0.
- `err_parity`  out  1  one-cycle pulse on parity mismatch; reset 0.
- `err_frame`  out  1  one-cycle pulse on stop bit sampled 0; reset 0.

## Operation
- Frame format: start (0), 8 data bits LSB first, even-parity bit, stop (1). Each bit lasts `CLK_DIV` cycles.
- Command: byte0[7] = 1 for write, 0 for read; byte0[6:0] = address. A write is followed by byte1 = write data. A read has no second byte.
- `rx` passes through a 2-FF synchronizer before any use.
- States: IDLE, RX_CMD, RX_DATA, WRITE, READ, CAPTURE, TX_RESP, WAIT_IDLE.
- IDLE -> RX_CMD on a synchronized falling edge of `rx`.
- RX_CMD / RX_DATA sampling:
  - Start bit is re-checked at `CLK_DIV/2`. If it is high, the start was false: return to IDLE, no error.
  - Data, parity and stop bits are sampled every `CLK_DIV` cycles after that.
- RX_CMD completes with a good stop and parity:
  - Write: latch address, go to RX_DATA. RX_DATA waits in its own idle phase for the next falling edge, then receives the frame the same way.
  - Read: latch address, go to READ.
- RX_DATA completes cleanly -> WRITE. WRITE asserts `reg_wr` for one cycle with `reg_addr`/`reg_wdata` valid, then goes to IDLE.
- READ asserts `reg_rd` for one cycle -> CAPTURE.
- CAPTURE latches `reg_rdata` into the shift register -> TX_RESP.
- TX_RESP shifts out start, 8 data bits LSB first, parity, stop; then goes to IDLE.
- Parity error: pulse `err_parity`, discard the command (no `reg_wr`/`reg_rd`), go to IDLE.
- Framing error (stop bit = 0): pulse `err_frame`, discard the command, go to WAIT_IDLE. WAIT_IDLE leaves for IDLE once the synchronized `rx` has been high for one full bit time.
- If parity and framing both fail, only `err_frame` is reported.
- `rx` is ignored during WRITE, READ, CAPTURE and TX_RESP (half-duplex). A frame arriving during TX_RESP is lost.
- No timeout in RX_DATA: a write command waits for its data byte indefinitely.
- Reset mid-operation: all state is cleared immediately, `tx` returns to 1 asynchronously, and no strobe is issued.

## Timing
- Bit counter counts 0..`CLK_DIV`-1 and wraps. Sample points are at `CLK_DIV/2` within each bit.
- Falling-edge detect adds 2 cycles of synchronizer latency.
- `reg_wr` is asserted in the cycle after the byte1 stop-bit sample.
- `reg_rd` is asserted in the cycle after the byte0 stop-bit sample; `reg_rdata` is captured one cycle later.
- The `tx` start bit begins in the cycle after capture.
- Response frame occupies exactly 11×`CLK_DIV` cycles; `busy` drops in the cycle after the stop bit ends.
- Error pulses occur in the cycle after the offending sample.

## Configuration
- `UART_CMD_PARITY_EN`:
  - Defined: frames carry the even-parity bit as above, checked on receive and generated on transmit.
  - Undefined: no parity bit (10-bit frames), `err_parity` tied to 0, and the stop bit follows data bit 7 directly.

## Test plan
Run with `CLK_DIV`=16, parity enabled unless noted.
- Write: send byte0 0x85, byte1 0x3C -> one `reg_wr` pulse with `reg_addr`=0x05, `reg_wdata`=0x3C; `tx` stays 1 throughout.
- Read: send byte0 0x12, drive `reg_rdata`=0xA5 -> one `reg_rd` pulse with `reg_addr`=0x12. `tx` then emits 0,1,0,1,0,0,1,0,1,0(parity),1, each 16 cycles; `busy` is low afterwards.
- Parity error: send byte0 0x85 with parity bit 0 -> `err_parity` pulse, no strobes; a following valid read of 0x01 completes normally.
- Framing error: send byte0 0x01 with stop bit 0, hold `rx` low for 40 cycles, then high -> `err_frame` pulse, no `reg_rd`; the block stays busy until `rx` has been high for 16 cycles.
- Glitches and reset: a 4-cycle low glitch on `rx` -> no error, block back in IDLE. Asserting `rst_n` low mid-way through a TX_RESP -> `tx`=1 and `busy`=0 immediately, with no further output.
- Parity disabled (macro undefined): 10-bit write frames 0x85 / 0x3C -> `reg_wr` with addr 0x05, data 0x3C; `err_parity` stays 0.
